// File: rtl/hash_unpack.sv
// Unpacks a 757 x 13-bit packed coefficient vector into the coefficient RAM,
// one word per cycle, starting at address 0.
module hash_unpack #(
    parameter int COEF_W = 13,
    parameter int ADDR_W = 11,
    parameter int MAX_N  = 757
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         degp,
    input  logic [COEF_W*MAX_N-1:0]   packed_data,
    output logic [ADDR_W-1:0]         mem_address_o,
    output logic [COEF_W-1:0]         mem_input,
    output logic                      mem_we,
    output logic                      busy,
    output logic                      done
);

    localparam int PACK_W = COEF_W * MAX_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Exposed as a named signal so checkers can bind to the FSM directly.
    state_t              state;
    logic [PACK_W-1:0]   shreg;
    logic [ADDR_W-1:0]   n;
    logic [ADDR_W-1:0]   i;
    logic [ADDR_W-1:0]   n_clamped;

    assign n_clamped = (degp > ADDR_W'(MAX_N)) ? ADDR_W'(MAX_N) : degp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            n             <= '0;
            i             <= '0;
            mem_address_o <= '0;
            mem_input     <= '0;
            mem_we        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        shreg <= packed_data;
                        n     <= n_clamped;
                        i     <= '0;
                        state <= (n_clamped == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    mem_we        <= 1'b1;
                    busy          <= 1'b1;
                    mem_address_o <= i;
                    mem_input     <= shreg[COEF_W-1:0];
                    shreg         <= shreg >> COEF_W;
                    i             <= i + ADDR_W'(1);
                    // n is at least 1 whenever WRITE is entered.
                    if (i == n - ADDR_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_unpack.sv
// Table-driven bench for hash_unpack: each row is one transfer with an
// optional re-start or reset injected mid-transfer.
module tb_hash_unpack;

    localparam int COEF_W = 13;
    localparam int ADDR_W = 11;
    localparam int MAX_N  = 757;
    localparam int PW     = COEF_W * MAX_N;

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  degp;
    logic [PW-1:0]      packed_data;
    logic [ADDR_W-1:0]  mem_address_o;
    logic [COEF_W-1:0]  mem_input;
    logic               mem_we;
    logic               busy;
    logic               done;

    hash_unpack #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .MAX_N(MAX_N)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .degp          (degp),
        .packed_data   (packed_data),
        .mem_address_o (mem_address_o),
        .mem_input     (mem_input),
        .mem_we        (mem_we),
        .busy          (busy),
        .done          (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int failed;
    logic [COEF_W-1:0] exp_q[$];

    typedef struct {
        int degp;        // requested count
        int kind;        // 0 ramp, 1 all ones, 2 random, 3 alternating
        int exp_n;       // expected number of writes (hand-computed clamp)
        int restart_at;  // cycle at which a second start is driven, -1 none
        int rst_at;      // cycle at which rst is driven, -1 none
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] make_vec(input int kind);
        logic [PW-1:0] v;
        logic [12:0]   w;
        v = '0;
        for (int k = 0; k < MAX_N; k++) begin
            case (kind)
                0: w = 13'(k);
                1: w = 13'h1FFF;
                2: w = 13'($urandom_range(0, 8191));
                default: w = (k % 2 == 0) ? 13'h1555 : 13'h0AAA;
            endcase
            v[k*COEF_W +: COEF_W] = w;
        end
        return v;
    endfunction

    // driver + per-cycle monitor for one transfer
    task automatic run(input vec_t t, input int row);
        logic [PW-1:0] vec;
        int last;
        int exp_addr;
        logic exp_we;
        logic exp_done;
        logic [COEF_W-1:0] d;
        vec = make_vec(t.kind);
        for (int k = 0; k < t.exp_n; k++) exp_q.push_back(vec[k*COEF_W +: COEF_W]);
        exp_addr = 0;

        @(negedge clk);
        start       = 1'b1;
        degp        = ADDR_W'(t.degp);
        packed_data = vec;
        @(negedge clk);
        start       = 1'b0;
        degp        = ADDR_W'($urandom_range(0, 2047));
        packed_data = ~vec;

        last = (t.rst_at >= 0) ? t.rst_at + 3 : t.exp_n + 3;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_we   = (c >= 1) && (c <= t.exp_n) && (t.rst_at < 0 || c <= t.rst_at);
            exp_done = (c == t.exp_n + 1) && (t.rst_at < 0);
            check($sformatf("r%0d mem_we", row), c, 32'(mem_we), 32'(exp_we));
            check($sformatf("r%0d busy", row), c, 32'(busy), 32'(exp_we));
            check($sformatf("r%0d done", row), c, 32'(done), 32'(exp_done));
            if (exp_we && mem_we) begin
                d = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0;
                check($sformatf("r%0d addr", row), c, 32'(mem_address_o), 32'(exp_addr));
                check($sformatf("r%0d data", row), c, 32'(mem_input), 32'(d));
                exp_addr++;
            end
            if (t.rst_at < 0 && t.exp_n > 0 && c > t.exp_n)
                check($sformatf("r%0d addr_hold", row), c, 32'(mem_address_o), 32'(t.exp_n - 1));
            if (t.rst_at >= 0 && c == t.rst_at + 1) begin
                check($sformatf("r%0d addr_rst", row), c, 32'(mem_address_o), 32'h0);
                check($sformatf("r%0d data_rst", row), c, 32'(mem_input), 32'h0);
            end
            // injections are driven after sampling so they land on the next edge
            if (c == t.restart_at) begin
                start       = 1'b1;
                degp        = ADDR_W'(5);
                packed_data = make_vec(1);
            end else begin
                start = 1'b0;
            end
            if (c == t.rst_at) rst = 1'b1;
            else               rst = 1'b0;
        end
        if (t.rst_at < 0)
            check($sformatf("r%0d write_count", row), last, 32'(exp_addr), 32'(t.exp_n));
        exp_q.delete();
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        degp        = '0;
        packed_data = '0;

        vecs[0] = '{degp: 757,  kind: 0, exp_n: 757, restart_at: -1, rst_at: -1};
        vecs[1] = '{degp: 1,    kind: 1, exp_n: 1,   restart_at: -1, rst_at: -1};
        vecs[2] = '{degp: 0,    kind: 0, exp_n: 0,   restart_at: -1, rst_at: -1};
        vecs[3] = '{degp: 2000, kind: 2, exp_n: 757, restart_at: -1, rst_at: -1};
        vecs[4] = '{degp: 757,  kind: 0, exp_n: 757, restart_at: 10, rst_at: -1};
        vecs[5] = '{degp: 757,  kind: 0, exp_n: 757, restart_at: -1, rst_at: 100};
        vecs[6] = '{degp: 3,    kind: 0, exp_n: 3,   restart_at: -1, rst_at: -1};
        vecs[7] = '{degp: 4,    kind: 3, exp_n: 4,   restart_at: 4,  rst_at: -1};
        vecs[8] = '{degp: 2047, kind: 1, exp_n: 757, restart_at: -1, rst_at: -1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst mem_we", 0, 32'(mem_we), 32'h0);
        check("rst busy", 0, 32'(busy), 32'h0);
        check("rst done", 0, 32'(done), 32'h0);
        check("rst addr", 0, 32'(mem_address_o), 32'h0);
        check("rst data", 0, 32'(mem_input), 32'h0);

        for (int r = 0; r < 9; r++) run(vecs[r], r);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
